pps_fetch: RTL and testbench

//  Instruction-fetch stage feeding PPS_Decode. Holds the PC and issues word reads to the instruction SRAM

---
 rtl/pps_fetch.sv | 152 +++++++++++++++
 tb/tb_pps_fetch.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pps_fetch.sv
// Instruction-fetch stage: PC, req/ack SRAM reads, 2-entry prefetch buffer, and
// registered instruction/PC+4 outputs to decode with taken-branch redirect.
`timescale 1ns/1ps
module pps_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INST  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ID_stall_in,
  input  logic        ID_Pstomp_in,
  input  logic [31:0] ID_bra_tgt_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ack_in,
  input  logic [31:0] imem_rdata_in,
  output logic [31:0] IF_inst_out,
  output logic [31:0] IF_PC_out,
  output logic        IF_valid_out
);

  localparam logic [1:0] DEPTH = 2'(BUF_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_req, w_req_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_buf_inst [2];
  logic [31:0] r_buf_pc   [2];
  logic [1:0]  r_cnt, w_cnt_nxt, w_widx;
  logic [31:0] r_inst, r_pc_out;
  logic        r_valid;

  logic        w_ack, w_acc, w_busy, w_pop, w_bypass, w_push;
  logic [31:0] w_ack_pc, w_tgt;
  logic        w_unused;

  assign w_unused = ^ID_bra_tgt_in[1:0];
  assign w_tgt    = {ID_bra_tgt_in[31:2], 2'b00};

  // Acks are only meaningful while a request is outstanding; strays are ignored.
  assign w_ack    = imem_ack_in & r_req;
  assign w_acc    = w_ack & (r_state == S_FETCH) & ~ID_Pstomp_in;
  assign w_busy   = r_req & ~w_ack;
  assign w_ack_pc = r_addr + 32'd4;
  assign w_pop    = ~ID_Pstomp_in & ~ID_stall_in & (r_cnt != 2'd0);
  assign w_bypass = ~ID_Pstomp_in & ~ID_stall_in & (r_cnt == 2'd0) & w_acc;
  assign w_push   = w_acc & ~w_bypass;
  assign w_widx   = r_cnt - {1'b0, w_pop};

  always_comb begin
    w_cnt_nxt = r_cnt - {1'b0, w_pop} + {1'b0, w_push};
    if (ID_Pstomp_in) w_cnt_nxt = '0;
    w_pc_nxt = r_pc;
    if (ID_Pstomp_in)  w_pc_nxt = w_tgt;
    else if (w_acc)    w_pc_nxt = r_pc + 32'd4;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = w_busy;
    w_addr_nxt  = r_addr;
    case (r_state)
      S_IDLE:  w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (ID_Pstomp_in && w_busy) begin
          w_state_nxt = S_DRAIN;
        end else if (!w_busy && (w_cnt_nxt < DEPTH)) begin
          w_req_nxt  = 1'b1;
          w_addr_nxt = w_pc_nxt;
        end
      end
      S_DRAIN: begin
        // The drained ack frees the port; the (possibly re-redirected) pc goes out next.
        if (w_ack) begin
          w_state_nxt = S_FETCH;
          w_req_nxt   = 1'b1;
          w_addr_nxt  = w_pc_nxt;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_req   <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_req   <= w_req_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt         <= '0;
      r_buf_inst[0] <= '0;
      r_buf_inst[1] <= '0;
      r_buf_pc[0]   <= '0;
      r_buf_pc[1]   <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_pop) begin
        r_buf_inst[0] <= r_buf_inst[1];
        r_buf_pc[0]   <= r_buf_pc[1];
      end
      if (w_push) begin
        r_buf_inst[w_widx[0]] <= imem_rdata_in;
        r_buf_pc[w_widx[0]]   <= w_ack_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inst   <= NOP_INST;
      r_pc_out <= '0;
      r_valid  <= 1'b0;
    end else if (ID_Pstomp_in) begin
      r_inst  <= NOP_INST;
      r_valid <= 1'b0;
    end else if (!ID_stall_in) begin
      if (r_cnt != 2'd0) begin
        r_inst   <= r_buf_inst[0];
        r_pc_out <= r_buf_pc[0];
        r_valid  <= 1'b1;
      end else if (w_acc) begin
        r_inst   <= imem_rdata_in;
        r_pc_out <= w_ack_pc;
        r_valid  <= 1'b1;
      end else begin
        r_inst  <= NOP_INST;
        r_valid <= 1'b0;
      end
    end
  end

  assign imem_req_out  = r_req;
  assign imem_addr_out = r_addr;
  assign IF_inst_out   = r_inst;
  assign IF_PC_out     = r_pc_out;
  assign IF_valid_out  = r_valid;

endmodule

// File: tb/tb_pps_fetch.sv
// Bench for pps_fetch: directed scenarios plus a randomized run checked against
// a stream-level model (sequential fetch addresses, buffer occupancy, redirects).
`timescale 1ns/1ps
module tb_pps_fetch;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, pstomp = 1'b0;
  logic [31:0] tgt = '0;
  logic        req, ack = 1'b0, valid;
  logic [31:0] addr, rdata = '0, inst, pco;
  int          checks = 0, errors = 0;
  int          mem_mode = 0;
  logic        force_ack = 1'b0, stray = 1'b0, req_seen = 1'b0;

  always #5 clk = ~clk;

  pps_fetch #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .ID_stall_in(stall), .ID_Pstomp_in(pstomp), .ID_bra_tgt_in(tgt),
    .imem_req_out(req), .imem_addr_out(addr), .imem_ack_in(ack), .imem_rdata_in(rdata),
    .IF_inst_out(inst), .IF_PC_out(pco), .IF_valid_out(valid)
  );

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h0) return 32'h2408_0005;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory: never acks in the first cycle a request is visible.
  always @(posedge clk or negedge rst)
    if (!rst) req_seen <= 1'b0;
    else      req_seen <= req;

  always @(negedge clk) begin
    ack   <= stray | (rst & req & req_seen &
             ((mem_mode == 0) | ((mem_mode == 1) & ($urandom % 2 == 1)) | ((mem_mode == 3) & force_ack)));
    rdata <= stray ? 32'hDEAD_BEEF : memword(addr);
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic apply_reset;
    @(negedge clk); rst = 1'b0; stall = 1'b0; pstomp = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (!valid && n < limit) begin tick; n++; end
  endtask

  task automatic test_reset;
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (req !== 1'b0)   begin errors++; $display("FAIL reset_req got %b want 0", req); end
    checks++; if (addr !== '0)    begin errors++; $display("FAIL reset_addr got %h want 0", addr); end
    checks++; if (inst !== NOP)   begin errors++; $display("FAIL reset_inst got %h want %h", inst, NOP); end
    checks++; if (pco !== '0)     begin errors++; $display("FAIL reset_pc got %h want 0", pco); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
  endtask

  task automatic test_first_fetch;
    int n;
    mem_mode = 0;
    @(posedge clk); #1; rst = 1'b1; stray = 1'b1;
    tick; tick; stray = 1'b0;
    checks++; if (!(req === 1'b1 && addr === 32'h0))
      begin errors++; $display("FAIL first_req got req=%b addr=%h want req=1 addr=0", req, addr); end
    wait_valid(10, n);
    checks++; if (valid !== 1'b1)          begin errors++; $display("FAIL first_valid got %b want 1", valid); end
    checks++; if (inst !== 32'h2408_0005)  begin errors++; $display("FAIL first_inst got %h want 24080005", inst); end
    checks++; if (pco !== 32'h4)           begin errors++; $display("FAIL first_pc got %h want 4", pco); end
    checks++; if (!(req === 1'b1 && addr === 32'h4))
      begin errors++; $display("FAIL second_req got req=%b addr=%h want req=1 addr=4", req, addr); end
  endtask

  task automatic test_streaming;
    for (int i = 1; i < 8; i++) begin
      tick;
      checks++;
      if (!(valid === 1'b1 && pco === 32'(4 + 4 * i) && inst === memword(32'(4 * i))))
        begin errors++; $display("FAIL stream_%0d got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                                 i, valid, pco, inst, 32'(4 + 4 * i), memword(32'(4 * i))); end
    end
  endtask

  task automatic test_stall;
    logic [31:0] h_inst, h_pc;
    logic        h_valid, saw_drop;
    saw_drop = 1'b0;
    @(negedge clk); stall = 1'b1;
    h_inst = inst; h_pc = pco; h_valid = valid;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (!req) saw_drop = 1'b1;
      checks++;
      if (!(inst === h_inst && pco === h_pc && valid === h_valid))
        begin errors++; $display("FAIL stall_hold_%0d got pc=%h inst=%h want pc=%h inst=%h", i, pco, inst, h_pc, h_inst); end
    end
    checks++; if (saw_drop !== 1'b1) begin errors++; $display("FAIL stall_req_drop got %b want 1", saw_drop); end
    @(negedge clk); stall = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick;
      checks++;
      if (!(valid === 1'b1 && pco === h_pc + 32'(4 * i) && inst === memword(h_pc + 32'(4 * i - 4))))
        begin errors++; $display("FAIL stall_resume_%0d got v=%b pc=%h want v=1 pc=%h", i, valid, pco, h_pc + 32'(4 * i)); end
    end
  endtask

  task automatic test_redirect_drain;
    int n;
    mem_mode = 3; force_ack = 1'b1;
    apply_reset;
    n = 0;
    while (!(req && addr == 32'h18) && n < 40) begin tick; n++; end
    force_ack = 1'b0;
    checks++; if (!(req === 1'b1 && addr === 32'h18))
      begin errors++; $display("FAIL drain_setup got req=%b addr=%h want req=1 addr=18", req, addr); end
    @(negedge clk); pstomp = 1'b1; tgt = 32'h100;
    tick;
    checks++; if (!(valid === 1'b0 && inst === NOP && req === 1'b1 && addr === 32'h18))
      begin errors++; $display("FAIL drain_enter got v=%b req=%b addr=%h want v=0 req=1 addr=18", valid, req, addr); end
    @(negedge clk); pstomp = 1'b0;
    tick;
    checks++; if (!(valid === 1'b0 && req === 1'b1 && addr === 32'h18))
      begin errors++; $display("FAIL drain_hold got v=%b req=%b addr=%h want v=0 req=1 addr=18", valid, req, addr); end
    force_ack = 1'b1;
    tick;
    checks++; if (!(valid === 1'b0 && req === 1'b1 && addr === 32'h100))
      begin errors++; $display("FAIL drain_target got v=%b req=%b addr=%h want v=0 req=1 addr=100", valid, req, addr); end
    wait_valid(10, n);
    checks++; if (!(valid === 1'b1 && pco === 32'h104 && inst === memword(32'h100)))
      begin errors++; $display("FAIL drain_first got v=%b pc=%h inst=%h want v=1 pc=104 inst=%h", valid, pco, inst, memword(32'h100)); end
  endtask

  task automatic test_redirect_ack;
    int n;
    repeat (3) tick;
    @(negedge clk); #2; pstomp = 1'b1; tgt = 32'h203;
    tick;
    checks++; if (!(valid === 1'b0 && req === 1'b1 && addr === 32'h200))
      begin errors++; $display("FAIL ackstomp_req got v=%b req=%b addr=%h want v=0 req=1 addr=200", valid, req, addr); end
    @(negedge clk); pstomp = 1'b0;
    wait_valid(10, n);
    checks++; if (!(valid === 1'b1 && pco === 32'h204 && inst === memword(32'h200)))
      begin errors++; $display("FAIL ackstomp_first got v=%b pc=%h inst=%h want v=1 pc=204", valid, pco, inst); end
  endtask

  task automatic test_wrap;
    int n;
    @(negedge clk); #2; pstomp = 1'b1; tgt = 32'hFFFF_FFFC;
    tick;
    @(negedge clk); pstomp = 1'b0;
    wait_valid(10, n);
    checks++; if (!(valid === 1'b1 && pco === 32'h0 && inst === memword(32'hFFFF_FFFC)))
      begin errors++; $display("FAIL wrap_pc got v=%b pc=%h inst=%h want v=1 pc=0", valid, pco, inst); end
    checks++; if (!(req === 1'b1 && addr === 32'h0))
      begin errors++; $display("FAIL wrap_req got req=%b addr=%h want req=1 addr=0", req, addr); end
    tick;
    checks++; if (!(valid === 1'b1 && pco === 32'h4 && inst === 32'h2408_0005))
      begin errors++; $display("FAIL wrap_next got v=%b pc=%h inst=%h want v=1 pc=4 inst=24080005", valid, pco, inst); end
    @(negedge clk);
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL midreset_pre got req=%b want 1", req); end
    rst = 1'b0; #1;
    checks++; if (!(req === 1'b0 && addr === '0 && valid === 1'b0))
      begin errors++; $display("FAIL midreset got req=%b addr=%h v=%b want 0 0 0", req, addr, valid); end
  endtask

  task automatic test_random;
    logic [31:0] exp_pc, fetch_pc, p_addr, p_inst, p_pc;
    logic        p_req, p_ack, p_valid, drain, acc;
    int          occ, idle;
    exp_pc = '0; fetch_pc = '0; occ = 0; idle = 0; drain = 1'b0;
    mem_mode = 1;
    @(negedge clk); rst = 1'b1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      stall  = ($urandom % 100) < 30;
      pstomp = ($urandom % 100) < 4;
      tgt    = ($urandom % 8 == 0) ? (32'hFFFF_FFF0 | 32'($urandom % 16)) : 32'($urandom % 4096);
      #2;
      p_req = req; p_addr = addr; p_ack = ack; p_inst = inst; p_pc = pco; p_valid = valid;
      tick;
      if (pstomp) begin
        checks++; if (!(valid === 1'b0 && inst === NOP))
          begin errors++; $display("FAIL rnd_stomp c%0d got v=%b inst=%h want v=0", cyc, valid, inst); end
        occ = 0; drain = p_req & ~p_ack; idle = 0;
        exp_pc = {tgt[31:2], 2'b00}; fetch_pc = exp_pc;
      end else begin
        acc = p_req & p_ack & ~drain;
        if (p_req & p_ack) drain = 1'b0;
        if (acc) begin
          checks++; if (p_addr !== fetch_pc)
            begin errors++; $display("FAIL rnd_fetch_addr c%0d got %h want %h", cyc, p_addr, fetch_pc); end
          fetch_pc += 32'd4; occ++;
        end
        if (stall) begin
          checks++; if (!(inst === p_inst && pco === p_pc && valid === p_valid))
            begin errors++; $display("FAIL rnd_hold c%0d got pc=%h inst=%h want pc=%h inst=%h", cyc, pco, inst, p_pc, p_inst); end
        end else if (occ > 0) begin
          checks++; if (!(valid === 1'b1 && inst === memword(exp_pc) && pco === exp_pc + 32'd4))
            begin errors++; $display("FAIL rnd_out c%0d got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                                     cyc, valid, pco, inst, exp_pc + 32'd4, memword(exp_pc)); end
          exp_pc += 32'd4; occ--; idle = 0;
        end else begin
          checks++; if (!(valid === 1'b0 && inst === NOP && pco === p_pc))
            begin errors++; $display("FAIL rnd_bubble c%0d got v=%b pc=%h want v=0 pc=%h", cyc, valid, pco, p_pc); end
          idle++;
        end
      end
      checks++; if (occ + int'(req) > 2)
        begin errors++; $display("FAIL rnd_throttle c%0d got %0d want <=2", cyc, occ + int'(req)); end
      checks++; if (addr[1:0] !== 2'b00)
        begin errors++; $display("FAIL rnd_align c%0d got %h", cyc, addr); end
      if (p_req && !p_ack) begin
        checks++; if (!(req === 1'b1 && addr === p_addr))
          begin errors++; $display("FAIL rnd_req_stable c%0d got req=%b addr=%h want req=1 addr=%h", cyc, req, addr, p_addr); end
      end
      if (idle > 40) begin
        errors++; $display("FAIL rnd_progress c%0d got %0d idle cycles want <=40", cyc, idle);
        break;
      end
    end
    @(negedge clk); stall = 1'b0; pstomp = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_first_fetch;
    test_streaming;
    test_stall;
    test_redirect_drain;
    test_redirect_ack;
    test_wrap;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
